// File: rtl/tetris_axi_pkg.sv
// Shared types and helpers for the AXI4-Lite to tetromino BRAM bridge.
// Holds the FSM encoding, AXI response codes and byte-address decode helpers.
package tetris_axi_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WR_COLLECT = 3'd1,
    ST_WR_EXEC    = 3'd2,
    ST_WR_RESP    = 3'd3,
    ST_RD_EXEC    = 3'd4,
    ST_RD_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address to word index; the two byte-lane bits are dropped.
  function automatic logic [31:0] addr_to_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  // In range only if no index bits above awidth are set and the word exists.
  function automatic logic addr_in_range(input logic [31:0] byte_addr,
                                         input int unsigned awidth,
                                         input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = addr_to_index(byte_addr);
    return ((word_idx >> awidth) == 32'd0) && (word_idx < depth);
  endfunction

endpackage

// File: rtl/axi4_lite_bram_bridge_if.sv
// AXI4-Lite slave-side bundle for the tetromino BRAM bridge.
// The bridge connects through the slave modport; a host or bench uses master.
interface axi4_lite_bram_bridge_if #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AXI_AWIDTH = 8
);
  logic [AXI_AWIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;

  logic [DWIDTH-1:0]     s_wdata;
  logic [DWIDTH/8-1:0]   s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;

  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  logic [AXI_AWIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;

  logic [DWIDTH-1:0]     s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awaddr, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    output s_rready
  );

endinterface

// File: rtl/axi4_lite_bram_bridge.sv
// AXI4-Lite slave that serialises single writes/reads onto BRAM port 1.
// Out-of-range indices and partial strobes complete with SLVERR and never touch the BRAM.
module axi4_lite_bram_bridge
  import tetris_axi_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH     = 4,
  parameter int unsigned MEM_DEPTH  = 10,
  parameter int unsigned AXI_AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  axi4_lite_bram_bridge_if.slave s_axi,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  output logic              we1,
  output logic [DWIDTH-1:0] d1,
  input  logic [DWIDTH-1:0] q1
);

  if (AXI_AWIDTH < AWIDTH + 2) begin : g_awidth_check
    $error("AXI_AWIDTH must be at least AWIDTH+2");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_ready_en;
  logic                  r_aw_hit;
  logic                  r_w_hit;
  logic [AXI_AWIDTH-1:0] r_awaddr;
  logic [AXI_AWIDTH-1:0] r_araddr;
  logic [DWIDTH-1:0]     r_wdata;
  logic [DWIDTH/8-1:0]   r_wstrb;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;

  logic                  w_run;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic                  w_wr_legal;
  logic                  w_rd_legal;
  logic [AWIDTH-1:0]     w_wr_index;
  logic [AWIDTH-1:0]     w_rd_index;

  // Readies stay low while rst is high and for the first cycle after it.
  assign w_run = r_ready_en & ~rst;

  assign s_axi.s_awready = w_run & ~r_aw_hit &
                           ((r_state == ST_IDLE) | (r_state == ST_WR_COLLECT));
  assign s_axi.s_wready  = w_run & ~r_w_hit &
                           ((r_state == ST_IDLE) | (r_state == ST_WR_COLLECT));
  assign s_axi.s_arready = w_run & (r_state == ST_IDLE) &
                           ~(s_axi.s_awvalid | s_axi.s_wvalid);

  assign w_aw_hs   = s_axi.s_awvalid & s_axi.s_awready;
  assign w_w_hs    = s_axi.s_wvalid  & s_axi.s_wready;
  assign w_ar_hs   = s_axi.s_arvalid & s_axi.s_arready;
  assign w_aw_have = r_aw_hit | w_aw_hs;
  assign w_w_have  = r_w_hit  | w_w_hs;

  assign w_wr_index = AWIDTH'(addr_to_index(32'(r_awaddr)));
  assign w_rd_index = AWIDTH'(addr_to_index(32'(r_araddr)));
  assign w_wr_legal = addr_in_range(32'(r_awaddr), AWIDTH, MEM_DEPTH) && (r_wstrb == '1);
  assign w_rd_legal = addr_in_range(32'(r_araddr), AWIDTH, MEM_DEPTH);

  assign s_axi.s_bresp = r_bresp;
  assign s_axi.s_rresp = r_rresp;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state   = r_state;
    ce1            = 1'b0;
    we1            = 1'b0;
    addr1          = '0;
    d1             = '0;
    s_axi.s_bvalid = 1'b0;
    s_axi.s_rvalid = 1'b0;
    s_axi.s_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_aw_have && w_w_have)      w_next_state = ST_WR_EXEC;
        else if (w_aw_have || w_w_have) w_next_state = ST_WR_COLLECT;
        else if (w_ar_hs)               w_next_state = ST_RD_EXEC;
      end
      ST_WR_COLLECT: begin
        if (w_aw_have && w_w_have) w_next_state = ST_WR_EXEC;
      end
      ST_WR_EXEC: begin
        // A reset sampled in this cycle must not let the write through.
        if (w_wr_legal) begin
          ce1   = ~rst;
          we1   = ~rst;
          addr1 = w_wr_index;
          d1    = r_wdata;
        end
        w_next_state = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        s_axi.s_bvalid = 1'b1;
        if (s_axi.s_bready) w_next_state = ST_IDLE;
      end
      ST_RD_EXEC: begin
        if (w_rd_legal) begin
          ce1   = ~rst;
          addr1 = w_rd_index;
        end
        w_next_state = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        s_axi.s_rvalid = 1'b1;
        // q1 holds the fetched word: ce1 stays low until the bridge leaves this state.
        if (r_rresp == RESP_OKAY) s_axi.s_rdata = q1;
        if (s_axi.s_rready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready_en <= 1'b0;
      r_aw_hit   <= 1'b0;
      r_w_hit    <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_state    <= w_next_state;
      r_ready_en <= 1'b1;
      if ((r_state == ST_WR_RESP) && s_axi.s_bready) begin
        r_aw_hit <= 1'b0;
        r_w_hit  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_hit <= 1'b1;
        if (w_w_hs)  r_w_hit  <= 1'b1;
      end
      if (r_state == ST_WR_EXEC) r_bresp <= w_wr_legal ? RESP_OKAY : RESP_SLVERR;
      if (r_state == ST_RD_EXEC) r_rresp <= w_rd_legal ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // NOTE: payload registers carry no reset; they are only read once the matching hit flag or state says they are valid.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= s_axi.s_awaddr;
    if (w_w_hs) begin
      r_wdata <= s_axi.s_wdata;
      r_wstrb <= s_axi.s_wstrb;
    end
    if (w_ar_hs) r_araddr <= s_axi.s_araddr;
  end

endmodule

// File: tb/tb_axi4_lite_bram_bridge.sv
// Directed bench for axi4_lite_bram_bridge with a registered single-port BRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_axi4_lite_bram_bridge;
  import tetris_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr1;
  logic        ce1;
  logic        we1;
  logic [31:0] d1;
  logic [31:0] q1;
  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;
  int n_ce  = 0;
  int n_we  = 0;

  always #5 clk = ~clk;

  axi4_lite_bram_bridge_if #(.DWIDTH(32), .AXI_AWIDTH(8)) axi ();

  axi4_lite_bram_bridge #(
    .DWIDTH(32), .AWIDTH(4), .MEM_DEPTH(10), .AXI_AWIDTH(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (axi),
    .addr1 (addr1),
    .ce1   (ce1),
    .we1   (we1),
    .d1    (d1),
    .q1    (q1)
  );

  always @(posedge clk) begin
    if (ce1) begin
      n_ce++;
      if (we1) begin
        n_we++;
        mem[addr1] <= d1;
      end else begin
        q1 <= mem[addr1];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_both(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic [1:0] resp, output logic bv);
    axi.s_awaddr  = addr;
    axi.s_awvalid = 1'b1;
    axi.s_wdata   = data;
    axi.s_wstrb   = strb;
    axi.s_wvalid  = 1'b1;
    axi.s_bready  = 1'b1;
    next_cycle();
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    next_cycle();
    bv   = axi.s_bvalid;
    resp = axi.s_bresp;
    next_cycle();
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                    output logic rv);
    axi.s_araddr  = addr;
    axi.s_arvalid = 1'b1;
    axi.s_rready  = 1'b1;
    next_cycle();
    axi.s_arvalid = 1'b0;
    next_cycle();
    rv   = axi.s_rvalid;
    data = axi.s_rdata;
    resp = axi.s_rresp;
    next_cycle();
  endtask

  initial begin
    logic [1:0]  resp;
    logic        bv;
    logic        rv;
    logic [31:0] rdat;
    int          ce0;
    int          we0;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    q1            = 32'h0;
    rst           = 1'b1;
    axi.s_awaddr  = 8'h0;
    axi.s_awvalid = 1'b0;
    axi.s_wdata   = 32'h0;
    axi.s_wstrb   = 4'h0;
    axi.s_wvalid  = 1'b0;
    axi.s_bready  = 1'b0;
    axi.s_araddr  = 8'h0;
    axi.s_arvalid = 1'b0;
    axi.s_rready  = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    #1;
    check("reset_ctrl", 64'({axi.s_awready, axi.s_wready, axi.s_arready, axi.s_bvalid,
                             axi.s_rvalid, axi.s_bresp, axi.s_rresp, ce1, we1}), 64'h0);
    check("reset_data", 64'({addr1, d1, axi.s_rdata}), 64'h0);
    rst = 1'b0;
    next_cycle();
    next_cycle();

    // Simultaneous AW/W to 0x08
    axi.s_awaddr  = 8'h08;
    axi.s_awvalid = 1'b1;
    axi.s_wdata   = 32'hDEADBEEF;
    axi.s_wstrb   = 4'hF;
    axi.s_wvalid  = 1'b1;
    axi.s_bready  = 1'b1;
    #1;
    check("t1_readies", 64'({axi.s_awready, axi.s_wready, axi.s_arready}), 64'b110);
    next_cycle();
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    #1;
    check("t1_bram_ctl", 64'({ce1, we1, addr1}), 64'({2'b11, 4'd2}));
    check("t1_bram_d1", 64'(d1), 64'hDEADBEEF);
    next_cycle();
    check("t1_bresp", 64'({axi.s_bvalid, axi.s_bresp, ce1}), 64'({1'b1, RESP_OKAY, 1'b0}));
    next_cycle();
    check("t1_bvalid_drop", 64'(axi.s_bvalid), 64'h0);
    check("t1_mem2", 64'(mem[2]), 64'hDEADBEEF);

    // W first, AW three cycles later to 0x24 (index 9)
    we0 = n_we;
    axi.s_wdata  = 32'h0BADF00D;
    axi.s_wstrb  = 4'hF;
    axi.s_wvalid = 1'b1;
    #1;
    check("t2_wready", 64'(axi.s_wready), 64'h1);
    next_cycle();
    axi.s_wvalid = 1'b0;
    #1;
    check("t2_collect_readies", 64'({axi.s_awready, axi.s_wready, axi.s_arready}), 64'b100);
    next_cycle();
    check("t2_collect_idle", 64'({axi.s_bvalid, ce1}), 64'h0);
    next_cycle();
    axi.s_awaddr  = 8'h24;
    axi.s_awvalid = 1'b1;
    #1;
    check("t2_awready", 64'(axi.s_awready), 64'h1);
    next_cycle();
    axi.s_awvalid = 1'b0;
    #1;
    check("t2_bram_ctl", 64'({ce1, we1, addr1}), 64'({2'b11, 4'd9}));
    next_cycle();
    check("t2_bresp", 64'({axi.s_bvalid, axi.s_bresp}), 64'({1'b1, RESP_OKAY}));
    next_cycle();
    check("t2_write_count", 64'(n_we - we0), 64'd1);
    check("t2_mem9", 64'(mem[9]), 64'h0BADF00D);

    // Read back 0x24 with exact latency
    axi.s_araddr  = 8'h24;
    axi.s_arvalid = 1'b1;
    axi.s_rready  = 1'b1;
    #1;
    check("t2_arready", 64'(axi.s_arready), 64'h1);
    next_cycle();
    axi.s_arvalid = 1'b0;
    #1;
    check("t2_rd_ctl", 64'({ce1, we1, addr1}), 64'({2'b10, 4'd9}));
    next_cycle();
    check("t2_rd_resp", 64'({axi.s_rvalid, axi.s_rresp, axi.s_rdata}),
          64'({1'b1, RESP_OKAY, 32'h0BADF00D}));
    next_cycle();
    check("t2_rvalid_drop", 64'(axi.s_rvalid), 64'h0);

    // Illegal accesses
    ce0 = n_ce;
    wr_both(8'h28, 32'h11111111, 4'hF, resp, bv);
    check("t3_wr_index10", 64'({bv, resp}), 64'({1'b1, RESP_SLVERR}));
    wr_both(8'h0C, 32'h22222222, 4'h3, resp, bv);
    check("t3_wr_strb3", 64'({bv, resp}), 64'({1'b1, RESP_SLVERR}));
    check("t3_wr_no_ce", 64'(n_ce - ce0), 64'd0);
    check("t3_mem3_untouched", 64'(mem[3]), 64'h0);
    rd(8'h3C, rdat, resp, rv);
    check("t3_rd_3c", 64'({rv, resp, rdat}), 64'({1'b1, RESP_SLVERR, 32'h0}));
    rd(8'h48, rdat, resp, rv);
    check("t3_rd_48_upper_bits", 64'({rv, resp, rdat}), 64'({1'b1, RESP_SLVERR, 32'h0}));
    check("t3_rd_no_ce", 64'(n_ce - ce0), 64'd0);

    // AW, W and AR together: write first, read after B
    axi.s_awaddr  = 8'h04;
    axi.s_awvalid = 1'b1;
    axi.s_wdata   = 32'hCAFE0004;
    axi.s_wstrb   = 4'hF;
    axi.s_wvalid  = 1'b1;
    axi.s_araddr  = 8'h04;
    axi.s_arvalid = 1'b1;
    axi.s_bready  = 1'b1;
    axi.s_rready  = 1'b1;
    #1;
    check("t4_readies", 64'({axi.s_awready, axi.s_wready, axi.s_arready}), 64'b110);
    next_cycle();
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    #1;
    check("t4_wr_exec", 64'({axi.s_arready, ce1, we1, addr1}), 64'({3'b011, 4'd1}));
    next_cycle();
    check("t4_wr_resp", 64'({axi.s_bvalid, axi.s_bresp, axi.s_arready}), 64'({1'b1, RESP_OKAY, 1'b0}));
    next_cycle();
    check("t4_ar_after_b", 64'({axi.s_arready, axi.s_bvalid}), 64'b10);
    next_cycle();
    axi.s_arvalid = 1'b0;
    #1;
    check("t4_rd_ctl", 64'({ce1, we1, addr1}), 64'({2'b10, 4'd1}));
    next_cycle();
    check("t4_rd_data", 64'({axi.s_rvalid, axi.s_rresp, axi.s_rdata}),
          64'({1'b1, RESP_OKAY, 32'hCAFE0004}));
    next_cycle();

    // B back-pressure for 5 cycles with competing requests
    we0 = n_we;
    axi.s_bready  = 1'b0;
    axi.s_awaddr  = 8'h00;
    axi.s_awvalid = 1'b1;
    axi.s_wdata   = 32'h12345678;
    axi.s_wstrb   = 4'hF;
    axi.s_wvalid  = 1'b1;
    next_cycle();
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      axi.s_awaddr  = 8'h20;
      axi.s_awvalid = 1'b1;
      axi.s_wdata   = 32'hFFFFFFFF;
      axi.s_wvalid  = 1'b1;
      axi.s_araddr  = 8'h00;
      axi.s_arvalid = 1'b1;
      #1;
      check("t5_b_stall", 64'({axi.s_bvalid, axi.s_bresp, axi.s_awready, axi.s_wready,
                               axi.s_arready, ce1}), 64'b1000000);
      next_cycle();
    end
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    axi.s_arvalid = 1'b0;
    axi.s_bready  = 1'b1;
    next_cycle();
    check("t5_b_release", 64'(axi.s_bvalid), 64'h0);
    check("t5_b_single_write", 64'({n_we - we0, mem[0]}), 64'({32'd1, 32'h12345678}));

    // R back-pressure for 5 cycles
    axi.s_rready  = 1'b0;
    axi.s_araddr  = 8'h00;
    axi.s_arvalid = 1'b1;
    next_cycle();
    axi.s_arvalid = 1'b0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      axi.s_awaddr  = 8'h20;
      axi.s_awvalid = 1'b1;
      axi.s_wvalid  = 1'b1;
      #1;
      check("t5_r_stall", 64'({axi.s_rvalid, axi.s_rresp, axi.s_awready, axi.s_wready,
                               axi.s_arready, ce1, axi.s_rdata}),
            64'({1'b1, RESP_OKAY, 4'b0000, 32'h12345678}));
      next_cycle();
    end
    axi.s_awvalid = 1'b0;
    axi.s_wvalid  = 1'b0;
    axi.s_rready  = 1'b1;
    next_cycle();
    check("t5_r_release", 64'(axi.s_rvalid), 64'h0);
    check("t5_r_no_write", 64'({n_we - we0, mem[8]}), 64'({32'd1, 32'h0}));

    // Reset in WR_COLLECT, after leaving bresp at SLVERR
    wr_both(8'h04, 32'h55555555, 4'h0, resp, bv);
    check("t6_pre_slverr", 64'({bv, resp}), 64'({1'b1, RESP_SLVERR}));
    axi.s_awaddr  = 8'h10;
    axi.s_awvalid = 1'b1;
    next_cycle();
    axi.s_awvalid = 1'b0;
    #1;
    check("t6_collect", 64'({axi.s_awready, axi.s_wready}), 64'b01);
    we0 = n_we;
    rst          = 1'b1;
    axi.s_wdata  = 32'h99999999;
    axi.s_wstrb  = 4'hF;
    axi.s_wvalid = 1'b1;
    #1;
    check("t6_wready_in_rst", 64'(axi.s_wready), 64'h0);
    next_cycle();
    rst          = 1'b0;
    axi.s_wvalid = 1'b0;
    #1;
    check("t6_post_rst_ctrl", 64'({axi.s_awready, axi.s_wready, axi.s_arready, axi.s_bvalid,
                                   axi.s_rvalid, axi.s_bresp, axi.s_rresp, ce1, we1}), 64'h0);
    check("t6_post_rst_data", 64'({addr1, d1, axi.s_rdata}), 64'h0);
    next_cycle();
    next_cycle();
    check("t6_no_write", 64'({n_we - we0, mem[4]}), 64'h0);
    wr_both(8'h10, 32'h44444444, 4'hF, resp, bv);
    check("t6_recover_wr", 64'({bv, resp, mem[4]}), 64'({1'b1, RESP_OKAY, 32'h44444444}));

    // Reset in RD_RESP holding an SLVERR
    axi.s_rready  = 1'b0;
    axi.s_araddr  = 8'h3C;
    axi.s_arvalid = 1'b1;
    next_cycle();
    axi.s_arvalid = 1'b0;
    next_cycle();
    check("t6_rd_resp", 64'({axi.s_rvalid, axi.s_rresp}), 64'({1'b1, RESP_SLVERR}));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("t6_rd_post_rst", 64'({axi.s_awready, axi.s_wready, axi.s_arready, axi.s_bvalid,
                                 axi.s_rvalid, axi.s_bresp, axi.s_rresp, ce1, we1, axi.s_rdata}), 64'h0);
    next_cycle();
    rd(8'h10, rdat, resp, rv);
    check("t6_recover_rd", 64'({rv, resp, rdat}), 64'({1'b1, RESP_OKAY, 32'h44444444}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_bram_bridge.md
# axi4_lite_bram_bridge

AXI4-Lite slave that lets the host processor load tetromino shape/colour words into `bram_tetromino` through its write-side port (addr1/ce1/we1/d1/q1). It converts AXI byte addresses to BRAM word indices and serialises write and read transactions onto the single BRAM port. It rejects out-of-range or partial-strobe accesses with SLVERR. The bridge sits between the AXI interconnect and the BRAM; `game_logic_core` keeps exclusive use of port 0.

## Interface
- DWIDTH, 32, AXI data width and BRAM word width
- AWIDTH, 4, BRAM word-address width
- MEM_DEPTH, 10, number of valid BRAM words
- AXI_AWIDTH, 8, AXI byte-address width; must be ≥ AWIDTH+2

Ports:
- clk  in  1  single clock for AXI and BRAM
- rst  in  1  synchronous, active-high reset
- s_awaddr / s_awvalid / s_awready  in/in/out  AXI_AWIDTH/1/1  write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  DWIDTH/DWIDTH/8/1/1  write data channel
- s_bresp / s_bvalid / s_bready  out/out/in  2/1/1  write response
- s_araddr / s_arvalid / s_arready  in/in/out  AXI_AWIDTH/1/1  read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  DWIDTH/2/1/1  read data channel
- addr1  out  AWIDTH  BRAM word index, taken from byte address bits [AWIDTH+1:2]
- ce1 / we1  out  1/1  BRAM enable and write enable
- d1  out  DWIDTH  BRAM write data
- q1  in  DWIDTH  BRAM read data, registered, 1 cycle after ce1 with we1=0

## Operation
- FSM states: IDLE, WR_COLLECT, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP.
- IDLE:
  - awready=wready=1 and arready=0 while any awvalid or wvalid is present; otherwise arready=1.
  - AW and W are captured independently into aw_hit and w_hit flags.
  - Both captured in the same cycle: go to WR_EXEC. Only one captured: go to WR_COLLECT.
  - Read accepted (arvalid with no write activity): go to RD_EXEC.
- WR_COLLECT: only the missing channel's ready is high. arready=0. Go to WR_EXEC once both are captured.
- WR_EXEC (1 cycle):
  - Write is legal when index < MEM_DEPTH and wstrb is all ones. Then ce1=we1=1, addr1=index, d1=wdata, and bresp=OKAY is latched.
  - Otherwise ce1=we1=0 and bresp=SLVERR (2'b10).
  - Next state is WR_RESP.
- WR_RESP: bvalid=1 until bready. On the handshake, clear the flags and return to IDLE.
- RD_EXEC (1 cycle):
  - Legal index: ce1=1, we1=0, addr1=index.
  - Illegal index: ce1=0 and rresp=SLVERR is latched.
  - Next state is RD_RESP.
- RD_RESP:
  - rvalid=1 until rready, then return to IDLE.
  - s_rdata = q1 on OKAY, 0 on SLVERR. q1 stays stable because ce1 is low throughout.
- Priority: when AW, W and AR all arrive in IDLE, the write wins. AR stays pending, since arready is low, and is served after B completes.
- One outstanding transaction at a time; no pipelining.
- Index bits above AWIDTH+1 in the byte address must be zero; otherwise the access is out of range (SLVERR).
- Low address bits [1:0] are ignored.

## Timing
- Reset value of every output is 0: all readies, bvalid, rvalid, bresp, rresp, rdata, ce1, we1, addr1, d1. State returns to IDLE and flags clear.
- Reset asserted mid-transaction aborts it. No BRAM write occurs after the cycle in which rst is sampled high.
- Write, both channels in cycle T: BRAM write in T+1, bvalid from T+2.
- Read, AR handshake in cycle T: ce1 in T+1, rvalid with valid rdata from T+2.
- Back-pressure: bvalid/rvalid and their payloads hold stable until the ready is sampled high. ce1 is never high outside WR_EXEC and RD_EXEC.
- Minimum spacing between accepted transactions is 3 cycles for a write and 3 cycles for a read, with bready/rready held high.

## Structure
- Shared package `tetris_axi_pkg`:
  - State encoding localparams.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Address-to-index helper function.
- Single module; no sub-module. The FSM and capture registers are one unit.
- Index decode and range check are combinational inside the module.

## Test plan
- AW=0x08 and W=0xDEADBEEF together, strb=F, bready=1 → ce1=we1=1, addr1=2 in T+1; bvalid in T+2 with bresp=OKAY; a BRAM model read of word 2 returns 0xDEADBEEF.
- W first, AW 3 cycles later (addr 0x24) → single BRAM write to index 9, bresp=OKAY. Then read 0x24 → rdata matches, rresp=OKAY, rvalid at AR+2.
- Write to 0x28 (index 10 = MEM_DEPTH) and write with strb=0x3 → no ce1 pulse, bresp=SLVERR. Read 0x3C → rresp=SLVERR, rdata=0.
- AW, W and AR asserted in the same cycle → write completes first; arready is held low until after the B handshake; the read then returns the newly written data.
- bready/rready held low for 5 cycles → bvalid/rvalid, bresp and rdata stay stable; no new transaction is accepted.
- rst pulsed in WR_COLLECT, and separately in RD_RESP → all outputs 0 next cycle; no BRAM write; the next transaction completes normally.
